// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard scheduler and related pipeline control blocks.
package pipe_pkg;
  typedef enum logic [0:0] {HZ_RUN, HZ_LU_STALL} hz_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read by ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  output logic       o_lu_hit
);
  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = i_id_uses_rs && (i_id_rs == i_ex_rt);
  assign w_rt_match = i_id_uses_rt && (i_id_rt == i_ex_rt);
  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign o_lu_hit   = i_ex_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler: load-use bubbles, EX redirect flushes and external freeze.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_redirect,
  input  logic        ext_stall,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  hz_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lu_hit;
  logic             w_stall;
  logic             w_flush;
  logic             w_busy;

  load_use_detect u_lud (
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rs (id_uses_rs),
    .i_id_uses_rt (id_uses_rt),
    .i_ex_mem_read(ex_mem_read),
    .i_ex_rt      (ex_rt),
    .o_lu_hit     (w_lu_hit)
  );

  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    w_busy  = 1'b0;
    if (!reset) begin
      w_busy = (r_state == HZ_LU_STALL);
      if (ex_redirect) begin
        w_flush = 1'b1;
      end else if ((r_state == HZ_LU_STALL) || w_lu_hit || ext_stall) begin
        w_stall = 1'b1;
      end
    end
  end

  assign pc_stall    = w_stall;
  assign if_id_stall = w_stall;
  assign id_ex_stall = w_stall;
  assign if_id_flush = w_flush;
  assign id_ex_flush = w_flush;
  assign busy        = w_busy;

  // The first bubble is issued from RUN, so LU_STALL covers the remaining N-1.
  always_ff @(posedge clk) begin
    if (reset || ex_redirect) begin
      r_state <= HZ_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        HZ_RUN: begin
          if (w_lu_hit && (LOAD_USE_BUBBLES > 1)) begin
            r_state <= HZ_LU_STALL;
            r_cnt   <= CNT_W'(LOAD_USE_BUBBLES - 1);
          end
        end
        HZ_LU_STALL: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= HZ_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= HZ_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_flush) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 bubbles) against a bubbles-remaining model.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_redirect, ext_stall;
  logic       pc1, ifs1, iff1, ids1, idf1, bz1;
  logic       pc3, ifs3, iff3, ids3, idf3, bz3;
  logic [5:0] o1, o3, e1, e3;
  int         checks = 0;
  int         errors = 0;
  int         rem1 = 0;
  int         rem3 = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ps1, pf1, ps3, pf3;
  logic [31:0] mps1 = '0, mpf1 = '0, mps3 = '0, mpf3 = '0;
`endif

  always #5 clk = ~clk;

  // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, busy}
  assign o1 = {pc1, ifs1, iff1, ids1, idf1, bz1};
  assign o3 = {pc3, ifs3, iff3, ids3, idf3, bz3};

  hazard_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .pc_stall(pc1), .if_id_stall(ifs1), .if_id_flush(iff1),
    .id_ex_stall(ids1), .id_ex_flush(idf1), .busy(bz1)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
  );

  hazard_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .pc_stall(pc3), .if_id_stall(ifs3), .if_id_flush(iff3),
    .id_ex_stall(ids3), .id_ex_flush(idf3), .busy(bz3)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(ps3), .perf_flush_cnt(pf3)
`endif
  );

  // A load in EX writing a nonzero register that the ID instruction actually reads.
  function automatic logic model_hit();
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
  endfunction

  // rem = bubbles still owed for the current load-use hazard (beyond this cycle's).
  function automatic logic [5:0] model_out(input int rem);
    logic b;
    if (reset) return 6'b000000;
    b = (rem > 0);
    if (ex_redirect) return {4'b0010, 1'b1, b};
    if (rem > 0 || model_hit() || ext_stall) return {5'b11010, b};
    return {5'b00000, b};
  endfunction

  function automatic int model_next(input int n, input int rem);
    if (reset || ex_redirect) return 0;
    if (rem > 0) return rem - 1;
    if (model_hit()) return n - 1;
    return 0;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mr, input logic [4:0] er,
                       input logic rd, input logic es, input logic rst);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = er; ex_redirect = rd; ext_stall = es; reset = rst;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hazard();
    drive(5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and move the model across the same edge.
  task automatic tick();
    int n1, n3;
    logic [5:0] x1, x3;
    n1 = model_next(1, rem1);
    n3 = model_next(3, rem3);
    x1 = model_out(rem1);
    x3 = model_out(rem3);
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (reset) begin
      mps1 = '0; mpf1 = '0; mps3 = '0; mpf3 = '0;
    end else begin
      mps1 = mps1 + {31'd0, x1[2]}; mpf1 = mpf1 + {31'd0, x1[1]};
      mps3 = mps3 + {31'd0, x3[2]}; mpf3 = mpf3 + {31'd0, x3[1]};
    end
`endif
    rem1 = n1;
    rem3 = n3;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      hazard();
      reset = 1'b1;
      ex_redirect = (i == 1);
      ext_stall = (i == 2);
      #1;
      checks++;
      if (o1 !== 6'b000000) begin errors++; $display("FAIL reset_out1 got %b exp %b", o1, 6'b000000); end
      checks++;
      if (o3 !== 6'b000000) begin errors++; $display("FAIL reset_out3 got %b exp %b", o3, 6'b000000); end
      tick();
    end
    idle();
    #1;
    checks++;
    if (o3 !== 6'b000000) begin errors++; $display("FAIL post_reset_idle got %b exp %b", o3, 6'b000000); end
    tick();
  endtask

  task automatic test_lu_single();
    int st1 = 0, st3 = 0, bz3c = 0, bz1c = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) hazard(); else idle();
      #1;
      e1 = model_out(rem1); e3 = model_out(rem3);
      checks++;
      if (o1 !== e1) begin errors++; $display("FAIL lu_cycle%0d_n1 got %b exp %b", c, o1, e1); end
      checks++;
      if (o3 !== e3) begin errors++; $display("FAIL lu_cycle%0d_n3 got %b exp %b", c, o3, e3); end
      st1 += int'(pc1 & ifs1 & ids1);
      st3 += int'(pc3 & ifs3 & ids3);
      bz1c += int'(bz1);
      bz3c += int'(bz3 && (c == 1 || c == 2));
      tick();
    end
    checks++;
    if (st1 !== 1) begin errors++; $display("FAIL lu_stall_cycles_n1 got %0d exp 1", st1); end
    checks++;
    if (st3 !== 3) begin errors++; $display("FAIL lu_stall_cycles_n3 got %0d exp 3", st3); end
    checks++;
    if (bz1c !== 0) begin errors++; $display("FAIL lu_busy_n1 got %0d exp 0", bz1c); end
    checks++;
    if (bz3c !== 2) begin errors++; $display("FAIL lu_busy_n3 got %0d exp 2", bz3c); end
  endtask

  task automatic test_no_hazard();
    drive(5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o3 !== 6'b000000) begin errors++; $display("FAIL zero_reg_n3 got %b exp %b", o3, 6'b000000); end
    tick();
    drive(5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o1 !== 6'b000000) begin errors++; $display("FAIL rt_unused_n1 got %b exp %b", o1, 6'b000000); end
    tick();
  endtask

  task automatic test_redirect_hit();
    hazard();
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (o1 !== 6'b001010) begin errors++; $display("FAIL redir_hit_n1 got %b exp %b", o1, 6'b001010); end
    checks++;
    if (o3 !== 6'b001010) begin errors++; $display("FAIL redir_hit_n3 got %b exp %b", o3, 6'b001010); end
    tick();
    idle();
    #1;
    checks++;
    if (o3 !== 6'b000000) begin errors++; $display("FAIL redir_hit_next_n3 got %b exp %b", o3, 6'b000000); end
    tick();
  endtask

  task automatic test_redirect_abort();
    hazard();
    tick();
    idle();
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (o3 !== 6'b001011) begin errors++; $display("FAIL abort_flush_n3 got %b exp %b", o3, 6'b001011); end
    tick();
    idle();
    #1;
    checks++;
    if (o3 !== 6'b000000) begin errors++; $display("FAIL abort_after_n3 got %b exp %b", o3, 6'b000000); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    hazard();
    tick();
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (o3 !== 6'b000000) begin errors++; $display("FAIL rst_mid_n3 got %b exp %b", o3, 6'b000000); end
    tick();
    idle();
    #1;
    checks++;
    if (o3 !== 6'b000000) begin errors++; $display("FAIL rst_mid_after_n3 got %b exp %b", o3, 6'b000000); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 49) == 0));
      #1;
      e1 = model_out(rem1); e3 = model_out(rem3);
      checks++;
      if (o1 !== e1) begin errors++; $display("FAIL rand%0d_n1 got %b exp %b", c, o1, e1); end
      checks++;
      if (o3 !== e3) begin errors++; $display("FAIL rand%0d_n3 got %b exp %b", c, o3, e3); end
      checks++;
      if ((iff3 & ifs3) !== 1'b0) begin errors++; $display("FAIL rand%0d_excl got 1 exp 0", c); end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if ({ps1, pf1} !== {mps1, mpf1})
        begin errors++; $display("FAIL rand%0d_perf1 got %0d/%0d exp %0d/%0d", c, ps1, pf1, mps1, mpf1); end
      checks++;
      if ({ps3, pf3} !== {mps3, mpf3})
        begin errors++; $display("FAIL rand%0d_perf3 got %0d/%0d exp %0d/%0d", c, ps3, pf3, mps3, mpf3); end
`endif
      tick();
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    idle(); reset = 1'b1; tick();
    hazard(); tick();
    idle(); tick();
    idle(); tick();
    idle(); tick();
    hazard(); tick();
    idle(); tick();
    idle(); tick();
    idle(); ex_redirect = 1'b1; tick();
    idle(); #1;
    checks++;
    if (ps1 !== 32'd2) begin errors++; $display("FAIL perf_stall_n1 got %0d exp 2", ps1); end
    checks++;
    if (pf1 !== 32'd1) begin errors++; $display("FAIL perf_flush_n1 got %0d exp 1", pf1); end
    checks++;
    if (ps3 !== 32'd6) begin errors++; $display("FAIL perf_stall_n3 got %0d exp 6", ps3); end
    tick();
  endtask
`endif

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_lu_single();
    test_no_hazard();
    test_redirect_hit();
    test_redirect_abort();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
